adder_arbiter: RTL and testbench
================================

# adder_arbiter

Round-robin arbiter that shares one `prefix_adder` instance between NREQ independent requesters. Each requester has a valid/ready request channel carrying two NBIT operands and a valid/ready response channel. One request is granted per cycle. The sum and carry-out are captured in a single result register and held until the owning requester accepts them. The block sits between the integer units that need occasional wide additions and the single shared adder datapath.

## Interface
Parameters:
- NBIT, 32, operand/sum width; passed to the internal `prefix_adder`.
- NREQ, 4, number of requesters; must be ≥ 2.
- IDW, $clog2(NREQ), requester-id width (derived, not overridden).

Ports (clock/reset: one clock; reset is synchronous and active-high):
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  bit i: requester i presents an operand pair.
- req_ready  output  NREQ  bit i: requester i's pair is accepted this cycle; at most one bit set.
- req_a  input  NREQ*NBIT  operand a; requester i occupies bits [i*NBIT +: NBIT].
- req_b  input  NREQ*NBIT  operand b; same packing as req_a.
- rsp_valid  output  NREQ  one-hot (or zero); bit i: result for requester i is present.
- rsp_ready  input  NREQ  bit i: requester i accepts its result this cycle.
- rsp_s  output  NBIT  registered sum, a+b mod 2^NBIT.
- rsp_cout  output  1  registered carry-out of a+b.
- rsp_id  output  IDW  index of the requester owning the held result.
- busy  output  1  result register occupied (equals |rsp_valid).

## Operation
State:
- prio: IDW-bit round-robin pointer naming the highest-priority requester.
- full: 1-bit result-register occupancy.
- res_s, res_cout, res_id: the held result.

Arbitration:
- Combinational grant search over req_valid, starting at prio and ascending with wrap-around (prio, prio+1, …, NREQ-1, 0, …).
- The first asserted index k is the candidate.
- No candidate when req_valid == 0.

Acceptance:
- drain = full & rsp_ready[res_id].
- space = ~full | drain.
- req_ready[k] = space for candidate k; all other req_ready bits are 0.
- A transfer occurs when req_valid[k] & req_ready[k].

On transfer:
- The candidate's operands are muxed into the shared `prefix_adder`.
- res_s, res_cout and res_id (=k) are loaded and full is set.
- prio updates to (k+1) mod NREQ. If k = NREQ-1, prio wraps to 0.

Without transfer:
- full clears on drain.
- prio and the held result are unchanged.

Simultaneous drain and transfer in the same cycle:
- The new result replaces the old one.
- full stays 1.
- Zero-bubble throughput: one add per cycle.

Held result:
- rsp_valid = full ? onehot(res_id) : 0.
- rsp_s, rsp_cout and rsp_id are driven from their registers.
- rsp_ready bits other than res_id are ignored.

Handshake rules:
- req_ready is independent of req_a and req_b.
- req_ready depends on req_valid only through the grant search.
- The block never combinationally routes req_* to rsp_*.
- Requester obligation: once valid is asserted, hold it and the operands stable until accepted.

Fairness:
- A requester holding valid is accepted within NREQ transfers.
- Between two grants to the same requester, every other continuously valid requester receives one grant.

## Timing
Reset values (reset asserted at an edge):
- prio=0, full=0.
- rsp_valid=0, busy=0.
- rsp_s=0, rsp_cout=0, rsp_id=0.
- Combinationally, req_ready=0 while reset is high.
- A held result is discarded when reset is asserted mid-operation; no response is ever issued for it.

Latency:
- A request accepted at edge T produces rsp_valid at T+1, i.e. visible in the cycle after acceptance.

Hold:
- The result is held indefinitely while rsp_ready[res_id]=0.
- All requesters see req_ready=0 during that time (backpressure).

Throughput:
- Sustained 1 transfer/cycle when the owner asserts rsp_ready continuously.

Reset release:
- The first cycle after reset deasserts can accept a request.
- Requester 0 has highest priority in that cycle.

## Test plan
- Single requester, back-to-back: reset, then requester 2 sends a=32'h0000_0005,b=32'h0000_0007 and then a=32'hFFFF_FFFF,b=32'h0000_0001 with rsp_ready[2]=1 held. Required:
  - rsp_valid=4'b0100, s=12, cout=0 one cycle after the first acceptance.
  - s=0, cout=1 in the next cycle.
  - No bubble between the two results.
- Round-robin fairness: all four requesters continuously valid, rsp_ready=4'hF. Required:
  - rsp_id sequence 0,1,2,3,0,1,…
  - Each req_ready pulses exactly once per 4 cycles.
- Pointer wrap and skip: prio=3, with only requesters 1 and 3 valid. Required:
  - Grant 3, then 1 (wrapping past 0), then 3.
  - Requesters 0 and 2 never see req_ready.
- Backpressure: requester 1 result held with rsp_ready[1]=0 for 5 cycles while requester 0 is valid. Required:
  - rsp_s and rsp_id stable.
  - req_ready=0 for all 5 cycles.
  - In the cycle rsp_ready[1] rises, req_ready[0]=1; requester 0's result is visible in the next cycle.
- Reset mid-operation: assert reset while full=1 and requesters 0 and 3 are valid. Required:
  - Next cycle rsp_valid=0, busy=0, rsp_s=0.
  - After release, requester 0 is granted first.
  - The discarded result never appears.
- Randomized scoreboard: random valid/ready and operand traffic for 10k cycles. Required:
  - Every result matches {cout,s} = a+b (NBIT+1-bit).
  - Responses arrive in acceptance order.
  - rsp_valid is never multi-hot.
  - No requester waits more than NREQ grants.

Source files
------------

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one prefix adder between NREQ requesters, with a
// single result register held until its owner accepts it.

module prefix_adder #(
    parameter int NBIT = 32
) (
    input  logic [NBIT-1:0] a,
    input  logic [NBIT-1:0] b,
    output logic [NBIT-1:0] s,
    output logic            cout
);
    localparam int LV = (NBIT > 1) ? $clog2(NBIT) : 1;

    logic [NBIT-1:0] g;
    logic [NBIT-1:0] p;
    logic [NBIT-1:0] gn;
    logic [NBIT-1:0] pn;
    logic [NBIT:0]   c;

    // Kogge-Stone: after LV levels g[i] is the group generate of bits [i:0].
    always_comb begin
        g  = a & b;
        p  = a ^ b;
        gn = g;
        pn = p;
        for (int l = 0; l < LV; l++) begin
            gn = g;
            pn = p;
            for (int i = 0; i < NBIT; i++) begin
                if (i >= (1 << l)) begin
                    gn[i] = g[i] | (p[i] & g[i - (1 << l)]);
                    pn[i] = p[i] & p[i - (1 << l)];
                end
            end
            g = gn;
            p = pn;
        end
    end

    assign c    = {g, 1'b0};
    assign s    = (a ^ b) ^ c[NBIT-1:0];
    assign cout = c[NBIT];

endmodule

// state  | meaning
// S_EMPTY| result register free, any granted request loads it
// S_HELD | result held for res_id until rsp_ready[res_id]
module adder_arbiter #(
    parameter  int NBIT = 32,
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*NBIT-1:0] req_a,
    input  logic [NREQ*NBIT-1:0] req_b,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [NBIT-1:0]      rsp_s,
    output logic                 rsp_cout,
    output logic [IDW-1:0]       rsp_id,
    output logic                 busy
);
    typedef enum logic {
        S_EMPTY = 1'b0,
        S_HELD  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IDW-1:0]  prio;
    logic [NBIT-1:0] res_s;
    logic            res_cout;
    logic [IDW-1:0]  res_id;

    logic            full;
    logic            drain;
    logic            space;
    logic            found;
    logic [IDW-1:0]  cand;
    logic            transfer;
    logic [NBIT-1:0] op_a;
    logic [NBIT-1:0] op_b;
    logic [NBIT-1:0] sum;
    logic            carry;
    int              idx;

    assign full  = (state == S_HELD);
    assign drain = full & rsp_ready[res_id];
    assign space = ~full | drain;

    // Search ascends from prio with wrap-around; first valid index wins.
    always_comb begin
        found = 1'b0;
        cand  = '0;
        idx   = 0;
        for (int off = 0; off < NREQ; off++) begin
            idx = int'(prio) + off;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                cand  = IDW'(idx);
            end
        end
    end

    assign req_ready = (found && space && !reset) ? (NREQ'(1) << cand) : '0;
    assign transfer  = |(req_valid & req_ready);

    assign op_a = req_a[cand*NBIT +: NBIT];
    assign op_b = req_b[cand*NBIT +: NBIT];

    prefix_adder #(.NBIT(NBIT)) u_adder (
        .a    (op_a),
        .b    (op_b),
        .s    (sum),
        .cout (carry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (transfer) begin
            state_nxt = S_HELD;
        end else if (drain) begin
            state_nxt = S_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio     <= '0;
            res_s    <= '0;
            res_cout <= 1'b0;
            res_id   <= '0;
        end else if (transfer) begin
            res_s    <= sum;
            res_cout <= carry;
            res_id   <= cand;
            prio     <= (cand == IDW'(NREQ - 1)) ? '0 : cand + 1'b1;
        end
    end

    assign rsp_valid = full ? (NREQ'(1) << res_id) : '0;
    assign rsp_s     = res_s;
    assign rsp_cout  = res_cout;
    assign rsp_id    = res_id;
    assign busy      = full;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed and randomized checks of the round-robin shared-adder arbiter.

module tb_adder_arbiter;
    localparam int NBIT = 32;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*NBIT-1:0] req_a;
    logic [NREQ*NBIT-1:0] req_b;
    logic [NREQ-1:0]      rsp_valid;
    logic [NREQ-1:0]      rsp_ready;
    logic [NBIT-1:0]      rsp_s;
    logic                 rsp_cout;
    logic [IDW-1:0]       rsp_id;
    logic                 busy;

    int vectors    = 0;
    int miscompares = 0;

    adder_arbiter #(.NBIT(NBIT), .NREQ(NREQ)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_s     (rsp_s),
        .rsp_cout  (rsp_cout),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int i, input logic v, input logic [NBIT-1:0] a, input logic [NBIT-1:0] b);
        req_valid[i]            = v;
        req_a[i*NBIT +: NBIT]   = a;
        req_b[i*NBIT +: NBIT]   = b;
    endtask

    task automatic do_reset;
        reset     = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        req_a     = '0;
        req_b     = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        req_valid = 4'hF;
        rsp_ready = 4'hF;
        req_a     = '0;
        req_b     = '0;
        tick();
        tick();
        #1;
        vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL rst_ready got %b want 0000", req_ready); end
        vectors++; if (rsp_valid !== 4'b0000) begin miscompares++; $display("FAIL rst_rsp_valid got %b want 0000", rsp_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b want 0", busy); end
        vectors++; if ({rsp_cout, rsp_s} !== 33'h0) begin miscompares++; $display("FAIL rst_sum got %h want 0", {rsp_cout, rsp_s}); end
        vectors++; if (rsp_id !== 2'd0) begin miscompares++; $display("FAIL rst_id got %0d want 0", rsp_id); end
        reset = 1'b0;
        #1;
        vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL rst_release_ready got %b want 0001", req_ready); end
        req_valid = '0;
        tick();
    endtask

    task automatic test_back_to_back;
        do_reset();
        rsp_ready = 4'b0100;
        drive_req(2, 1'b1, 32'h0000_0005, 32'h0000_0007);
        #1;
        vectors++; if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL b2b_ready0 got %b want 0100", req_ready); end
        tick();
        drive_req(2, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001);
        #1;
        vectors++; if (rsp_valid !== 4'b0100) begin miscompares++; $display("FAIL b2b_valid0 got %b want 0100", rsp_valid); end
        vectors++; if ({rsp_cout, rsp_s} !== {1'b0, 32'd12}) begin miscompares++; $display("FAIL b2b_sum0 got %h want 00000000c", {rsp_cout, rsp_s}); end
        vectors++; if (rsp_id !== 2'd2) begin miscompares++; $display("FAIL b2b_id0 got %0d want 2", rsp_id); end
        vectors++; if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL b2b_ready1 got %b want 0100", req_ready); end
        tick();
        drive_req(2, 1'b0, '0, '0);
        #1;
        vectors++; if (rsp_valid !== 4'b0100) begin miscompares++; $display("FAIL b2b_valid1 got %b want 0100", rsp_valid); end
        vectors++; if ({rsp_cout, rsp_s} !== {1'b1, 32'd0}) begin miscompares++; $display("FAIL b2b_sum1 got %h want 100000000", {rsp_cout, rsp_s}); end
        tick();
        vectors++; if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin miscompares++; $display("FAIL b2b_drained got %b/%b want 0000/0", rsp_valid, busy); end
    endtask

    task automatic test_round_robin;
        int cnt[NREQ];
        logic [NBIT:0] e;
        do_reset();
        rsp_ready = 4'hF;
        for (int i = 0; i < NREQ; i++) begin
            cnt[i] = 0;
            drive_req(i, 1'b1, 32'h0000_0100 * i + 32'd3, 32'hFFFF_FE00 + i);
        end
        for (int c = 0; c < 8; c++) begin
            #1;
            vectors++; if (req_ready !== (4'b0001 << (c % 4))) begin miscompares++; $display("FAIL rr_ready c=%0d got %b want %b", c, req_ready, 4'b0001 << (c % 4)); end
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) cnt[i]++;
            tick();
            e = {1'b0, 32'h0000_0100 * (c % 4) + 32'd3} + {1'b0, 32'hFFFF_FE00 + (c % 4)};
            vectors++; if (rsp_id !== IDW'(c % 4)) begin miscompares++; $display("FAIL rr_id c=%0d got %0d want %0d", c, rsp_id, c % 4); end
            vectors++; if ({rsp_cout, rsp_s} !== e) begin miscompares++; $display("FAIL rr_sum c=%0d got %h want %h", c, {rsp_cout, rsp_s}, e); end
        end
        for (int i = 0; i < NREQ; i++) begin
            vectors++; if (cnt[i] != 2) begin miscompares++; $display("FAIL rr_pulses req=%0d got %0d want 2", i, cnt[i]); end
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_wrap_skip;
        int g[3] = '{3, 1, 3};
        do_reset();
        rsp_ready = 4'hF;
        drive_req(2, 1'b1, 32'd1, 32'd1);
        tick();
        drive_req(2, 1'b0, '0, '0);
        drive_req(1, 1'b1, 32'd10, 32'd20);
        drive_req(3, 1'b1, 32'd30, 32'd40);
        for (int c = 0; c < 3; c++) begin
            #1;
            vectors++; if (req_ready !== (4'b0001 << g[c])) begin miscompares++; $display("FAIL wrap_ready c=%0d got %b want %b", c, req_ready, 4'b0001 << g[c]); end
            tick();
            vectors++; if (rsp_id !== IDW'(g[c]) || rsp_s !== ((g[c] == 3) ? 32'd70 : 32'd30)) begin
                miscompares++; $display("FAIL wrap_rsp c=%0d got id %0d s %0d want id %0d", c, rsp_id, rsp_s, g[c]);
            end
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_backpressure;
        do_reset();
        rsp_ready = 4'b0000;
        drive_req(1, 1'b1, 32'h10, 32'h20);
        tick();
        drive_req(1, 1'b0, '0, '0);
        drive_req(0, 1'b1, 32'h111, 32'h222);
        for (int c = 0; c < 5; c++) begin
            #1;
            vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL bp_ready c=%0d got %b want 0000", c, req_ready); end
            vectors++; if (rsp_id !== 2'd1 || rsp_s !== 32'h30 || rsp_valid !== 4'b0010) begin
                miscompares++; $display("FAIL bp_hold c=%0d got id %0d s %h v %b want id 1 s 30 v 0010", c, rsp_id, rsp_s, rsp_valid);
            end
            tick();
        end
        rsp_ready = 4'b0010;
        #1;
        vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL bp_release got %b want 0001", req_ready); end
        tick();
        rsp_ready = 4'b0000;
        drive_req(0, 1'b0, '0, '0);
        #1;
        vectors++; if (rsp_valid !== 4'b0001 || rsp_id !== 2'd0 || rsp_s !== 32'h333) begin
            miscompares++; $display("FAIL bp_next got v %b id %0d s %h want v 0001 id 0 s 333", rsp_valid, rsp_id, rsp_s);
        end
        rsp_ready = 4'hF;
        tick();
    endtask

    task automatic test_reset_mid;
        do_reset();
        rsp_ready = 4'b0000;
        drive_req(3, 1'b1, 32'hAAAA_0000, 32'h0000_5555);
        tick();
        drive_req(3, 1'b1, 32'h1234, 32'h1);
        drive_req(0, 1'b1, 32'h50, 32'h5);
        reset = 1'b1;
        #1;
        vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL rmid_ready got %b want 0000", req_ready); end
        tick();
        vectors++; if (rsp_valid !== 4'b0000 || busy !== 1'b0 || rsp_s !== 32'h0) begin
            miscompares++; $display("FAIL rmid_clear got v %b busy %b s %h want 0000 0 0", rsp_valid, busy, rsp_s);
        end
        reset = 1'b0;
        rsp_ready = 4'hF;
        #1;
        vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL rmid_first got %b want 0001", req_ready); end
        tick();
        vectors++; if (rsp_id !== 2'd0 || rsp_s !== 32'h55 || rsp_valid !== 4'b0001) begin
            miscompares++; $display("FAIL rmid_rsp0 got id %0d s %h v %b want id 0 s 55 v 0001", rsp_id, rsp_s, rsp_valid);
        end
        drive_req(0, 1'b0, '0, '0);
        #1;
        vectors++; if (req_ready !== 4'b1000) begin miscompares++; $display("FAIL rmid_second got %b want 1000", req_ready); end
        tick();
        vectors++; if (rsp_id !== 2'd3 || rsp_s !== 32'h1235) begin
            miscompares++; $display("FAIL rmid_rsp3 got id %0d s %h want id 3 s 1235", rsp_id, rsp_s);
        end
        drive_req(3, 1'b0, '0, '0);
        tick();
        vectors++; if (rsp_valid !== 4'b0000) begin miscompares++; $display("FAIL rmid_stale got %b want 0000", rsp_valid); end
    endtask

    task automatic test_random;
        logic [IDW-1:0]      m_prio;
        logic                m_full;
        logic [IDW-1:0]      m_id;
        logic [IDW+NBIT:0]   q[$];
        logic [IDW+NBIT:0]   ent;
        logic [NREQ-1:0]     exp_ready;
        logic [NREQ-1:0]     exp_valid;
        logic [NBIT:0]       e;
        logic                space;
        logic                fnd;
        int                  gk;
        int                  k;
        int                  waitc[NREQ];
        int                  g_prev;
        logic [NBIT-1:0]     a;
        logic [NBIT-1:0]     b;
        do_reset();
        m_prio = '0;
        m_full = 1'b0;
        m_id   = '0;
        g_prev = -1;
        for (int i = 0; i < NREQ; i++) waitc[i] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (g_prev >= 0) drive_req(g_prev, 1'b0, '0, '0);
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
                    b = $urandom;
                    drive_req(i, 1'b1, a, b);
                end
            end
            rsp_ready = 4'($urandom_range(0, 15));
            #1;
            space = !m_full || rsp_ready[m_id];
            fnd = 1'b0;
            gk = 0;
            for (int off = 0; off < NREQ; off++) begin
                k = (int'(m_prio) + off) % NREQ;
                if (!fnd && req_valid[k]) begin fnd = 1'b1; gk = k; end
            end
            exp_ready = (fnd && space) ? (4'b0001 << gk) : 4'b0000;
            exp_valid = m_full ? (4'b0001 << m_id) : 4'b0000;
            vectors++; if (req_ready !== exp_ready) begin miscompares++; $display("FAIL rnd_ready cyc=%0d got %b want %b", cyc, req_ready, exp_ready); end
            vectors++; if (rsp_valid !== exp_valid || busy !== m_full) begin
                miscompares++; $display("FAIL rnd_valid cyc=%0d got %b busy %b want %b busy %b", cyc, rsp_valid, busy, exp_valid, m_full);
            end
            if (m_full && rsp_ready[m_id]) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++; $display("FAIL rnd_order cyc=%0d got response want none queued", cyc);
                end else begin
                    ent = q.pop_front();
                    if ({rsp_id, rsp_cout, rsp_s} !== ent) begin
                        miscompares++; $display("FAIL rnd_result cyc=%0d got %h want %h", cyc, {rsp_id, rsp_cout, rsp_s}, ent);
                    end
                end
                m_full = 1'b0;
            end
            g_prev = -1;
            if (exp_ready != 0) begin
                e = {1'b0, req_a[gk*NBIT +: NBIT]} + {1'b0, req_b[gk*NBIT +: NBIT]};
                q.push_back({IDW'(gk), e});
                for (int j = 0; j < NREQ; j++) begin
                    if (j != gk && req_valid[j]) begin
                        waitc[j]++;
                        vectors++; if (waitc[j] > NREQ - 1) begin miscompares++; $display("FAIL rnd_starve req=%0d got %0d grants waited want <= %0d", j, waitc[j], NREQ - 1); end
                    end
                end
                waitc[gk] = 0;
                m_prio = (gk == NREQ - 1) ? '0 : IDW'(gk + 1);
                m_id   = IDW'(gk);
                m_full = 1'b1;
                g_prev = gk;
            end
            tick();
        end
        req_valid = '0;
        rsp_ready = 4'hF;
        tick();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_round_robin();
        test_wrap_skip();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
